// File: rtl/sa_drain_collector.sv
// sa_drain_collector: collects the skewed drain outputs of a systolic array,
// deskews the columns into aligned row words, frames them into tiles of ROWS
// rows and buffers them in a first-word-fall-through FIFO with an AXI-style
// valid/ready output.
//
// Build option: define SA_DRAIN_OVF_CNT_EN to build the saturating count of
// dropped rows on ovf_count. Without it ovf_count is tied to zero.
//
// state | meaning
// IDLE  | row_cnt == 0, waiting for the first row of a tile
// FILL  | 0 < row_cnt < ROWS, tile partially collected
module sa_drain_collector #(
    parameter int D_W_ACC = 64,
    parameter int N       = 4,
    parameter int ROWS    = 4,
    parameter int DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*D_W_ACC-1:0] col_data,
    input  logic [N-1:0]         col_valid,
    output logic [N*D_W_ACC-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 tile_done,
    output logic                 overflow,
    output logic                 skew_err,
    output logic [15:0]          ovf_count
);

    localparam int W  = N * D_W_ACC;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    logic [N-1:0] dly_valid;
    logic [W-1:0] dly_data;

    // Column j arrives j cycles after column 0, so it is delayed by N-1-j
    // registers; the last column passes straight through.
    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_col
            localparam int L = N - 1 - j;
            if (L == 0) begin : g_direct
                assign dly_valid[j] = col_valid[j];
                assign dly_data[j*D_W_ACC +: D_W_ACC] = col_data[j*D_W_ACC +: D_W_ACC];
            end else begin : g_delay
                logic [L-1:0]       v_sh;
                logic [D_W_ACC-1:0] d_sh [L];

                // Valid shift register, cleared by reset to kill in-flight rows
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_sh <= '0;
                    end else begin
                        v_sh[0] <= col_valid[j];
                        for (int k = 1; k < L; k++) v_sh[k] <= v_sh[k-1];
                    end
                end

                // Data shift register; qualified by the valid chain only
                always_ff @(posedge clk) begin
                    d_sh[0] <= col_data[j*D_W_ACC +: D_W_ACC];
                    for (int k = 1; k < L; k++) d_sh[k] <= d_sh[k-1];
                end

                assign dly_valid[j] = v_sh[L-1];
                assign dly_data[j*D_W_ACC +: D_W_ACC] = d_sh[L-1];
            end
        end
    endgenerate

    logic         row_valid;
    logic [W-1:0] row_data;

    // Row formation: all columns aligned forms a row; a partial set is a skew fault
    always_ff @(posedge clk) begin
        if (rst) begin
            row_valid <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            row_valid <= &dly_valid;
            if ((|dly_valid) && !(&dly_valid)) skew_err <= 1'b1;
        end
    end

    // Aligned row data register, column order preserved
    always_ff @(posedge clk) begin
        row_data <= dly_data;
    end

    state_t        state, state_nxt;
    logic [RW-1:0] row_cnt, row_cnt_nxt;
    logic          row_last;

    // Tile framing state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            tile_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            tile_done <= row_valid && row_last;
        end
    end

    // Tile framing next state; dropped rows still advance the count
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        row_last    = (row_cnt == RW'(ROWS - 1));
        unique case (state)
            IDLE: begin
                if (row_valid) begin
                    if (row_last) begin
                        row_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        row_cnt_nxt = row_cnt + RW'(1);
                        state_nxt   = FILL;
                    end
                end
            end
            FILL: begin
                if (row_valid) begin
                    if (row_last) begin
                        row_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        row_cnt_nxt = row_cnt + RW'(1);
                        state_nxt   = FILL;
                    end
                end
            end
            default: begin
                row_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, rd_en, wr_en, drop;

    assign full  = (count == CW'(DEPTH));
    assign rd_en = m_valid && m_ready;
    // A full FIFO still takes a row when a word leaves in the same cycle
    assign wr_en = row_valid && (!full || rd_en);
    assign drop  = row_valid && full && !rd_en;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr]      <= row_data;
            last_mem[wr_ptr] <= row_last;
        end
    end

    // FIFO pointers, registered occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Outputs are forced to zero while empty so nothing stale shows after reset
    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign m_last  = m_valid && last_mem[rd_ptr];

`ifdef SA_DRAIN_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating count of dropped rows
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_sa_drain_collector.sv
// Testbench for sa_drain_collector: a scoreboard of expected row words is
// filled as stimulus is issued and emptied by an independent output monitor.
module tb_sa_drain_collector;

    localparam int D_W_ACC = 64;
    localparam int N       = 4;
    localparam int ROWS    = 4;
    localparam int DEPTH   = 16;
    localparam int W       = N * D_W_ACC;
`ifdef SA_DRAIN_OVF_CNT_EN
    localparam int EXP_OVF = 4;
`else
    localparam int EXP_OVF = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] col_data;
    logic [N-1:0] col_valid;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         tile_done;
    logic         overflow;
    logic         skew_err;
    logic [15:0]  ovf_count;

    sa_drain_collector #(.D_W_ACC(D_W_ACC), .N(N), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .col_data(col_data), .col_valid(col_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .tile_done(tile_done), .overflow(overflow), .skew_err(skew_err),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   row_ctr  = 0;
    int   n_pop    = 0;
    bit   rand_ready = 0;
    bit   lat_arm  = 0;
    int   first_v  = -1;
    int   last_cyc = -1;
    int   td_count = 0;
    int   t_start  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: every formed row advances the tile position; a row is
    // kept only if fewer than DEPTH words are pending ahead of it.
    task automatic model_push(input logic [W-1:0] d, input bit force_acc);
        exp_t e;
        e.data  = d;
        e.last  = (row_ctr == ROWS - 1);
        row_ctr = (row_ctr + 1) % ROWS;
        if (force_acc || exp_q.size() < DEPTH) exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Drives nrows rows with systolic skew. late_col >= 0 delays that column
    // by one extra cycle (a malformed row, never pushed to the model).
    task automatic feed(input int nrows, input int base, input bit rnd, input int late_col,
                        input int abort_c, input int pulse, input bit force_acc);
        logic [W-1:0] rd[$];
        logic [W-1:0] v;
        int len;
        for (int r = 0; r < nrows; r++) begin
            for (int k = 0; k < N; k++)
                v[k*D_W_ACC +: D_W_ACC] = rnd ? {$urandom, $urandom} : D_W_ACC'(base + 100*r + k);
            rd.push_back(v);
        end
        len = nrows + N - 1 + ((late_col >= 0) ? 1 : 0);
        if (pulse + 1 > len) len = pulse + 1;
        for (int c = 0; c < len; c++) begin
            if (abort_c >= 0 && c == abort_c) break;
            if (c == 0) t_start = cyc;
            if (c < nrows && late_col < 0) model_push(rd[c], force_acc);
            for (int k = 0; k < N; k++) begin
                int r;
                r = c - k - ((k == late_col) ? 1 : 0);
                if (r >= 0 && r < nrows) begin
                    col_valid[k] = 1'b1;
                    col_data[k*D_W_ACC +: D_W_ACC] = rd[r][k*D_W_ACC +: D_W_ACC];
                end else begin
                    col_valid[k] = 1'b0;
                    col_data[k*D_W_ACC +: D_W_ACC] = '0;
                end
            end
            if (pulse >= 0) m_ready = (c == pulse);
            tick();
        end
        col_valid = '0;
        col_data  = '0;
        if (pulse >= 0) m_ready = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        col_valid = '0;
        col_data  = '0;
        exp_q.delete();
        row_ctr   = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        @(negedge clk);
        chk({tag, "_m_valid"},   m_valid,   0);
        chk({tag, "_m_last"},    m_last,    0);
        chk({tag, "_tile_done"}, tile_done, 0);
        chk({tag, "_overflow"},  overflow,  0);
        chk({tag, "_skew_err"},  skew_err,  0);
        chk({tag, "_ovf_count"}, ovf_count, 0);
        chk({tag, "_m_data"},    m_data,    0);
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks that a
    // stalled word holds still.
    initial begin
        logic [W-1:0] hold_d;
        logic         hold_l;
        bit           hold;
        exp_t         e;
        hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data",  m_data,  hold_d);
                    chk("hold_last",  m_last,  hold_l);
                end
                if (lat_arm && m_valid && first_v < 0) first_v = cyc;
                if (lat_arm && tile_done) td_count++;
                if (m_valid && m_ready) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", m_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_data", m_data, e.data);
                        chk("row_last", m_last, e.last);
                        if (lat_arm && m_last) last_cyc = cyc;
                    end
                end
                hold   = m_valid && !m_ready;
                hold_d = m_data;
                hold_l = m_last;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        col_valid = '0;
        col_data  = '0;
        m_ready   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_clear("reset");

        // Single tile, ready held high: latency, ordering, framing
        m_ready  = 1'b1;
        tick();
        first_v  = -1;
        last_cyc = -1;
        td_count = 0;
        lat_arm  = 1;
        feed(4, 0, 0, -1, -1, -1, 0);
        wait_drain(50);
        repeat (3) tick();
        lat_arm = 0;
        chk("latency",        W'(first_v - t_start),  W'(N + 1));
        chk("last_row_cycle", W'(last_cyc - t_start), W'(N + ROWS));
        chk("tile_done_cnt",  W'(td_count),           W'(1));

        // Column 2 one cycle late: skew error, no write, framing unchanged
        feed(1, 5000, 0, 2, -1, -1, 0);
        repeat (4) tick();
        chk("skew_err_set",  skew_err, 1);
        chk("skew_no_write", m_valid,  0);
        feed(4, 6000, 0, -1, -1, -1, 0);
        wait_drain(50);

        // Reset after the second row of a tile, then a clean tile
        feed(3, 7000, 0, -1, 5, -1, 0);
        do_reset();
        check_clear("mid_reset");
        feed(4, 8000, 0, -1, -1, -1, 0);
        wait_drain(50);
        repeat (4) tick();
        chk("no_stale", m_valid, 0);

        // Five tiles into a stalled output: four rows dropped
        do_reset();
        m_ready = 1'b0;
        feed(20, 10000, 0, -1, -1, -1, 0);
        repeat (N + 3) tick();
        chk("ovf_flag",  overflow,  1);
        chk("ovf_count", ovf_count, EXP_OVF);
        chk("ovf_valid", m_valid,   1);
        n_pop   = 0;
        m_ready = 1'b1;
        wait_drain(100);
        chk("ovf_drained", W'(n_pop), W'(DEPTH));
        repeat (3) tick();
        chk("ovf_empty", m_valid, 0);

        // Full FIFO: simultaneous read and write must keep the new row
        do_reset();
        m_ready = 1'b0;
        feed(16, 20000, 0, -1, -1, -1, 0);
        repeat (N + 3) tick();
        n_pop = 0;
        feed(1, 30000, 0, -1, -1, N, 1);
        repeat (3) tick();
        chk("full_rw_no_ovf", overflow, 0);
        chk("full_rw_valid",  m_valid,  1);
        m_ready = 1'b1;
        wait_drain(100);
        chk("full_rw_words", W'(n_pop), W'(DEPTH + 1));

        // Random data and random backpressure across several tiles
        do_reset();
        rand_ready = 1;
        for (int t = 0; t < 8; t++) begin
            int k = 0;
            while (exp_q.size() > 8 && k < 200) begin
                tick();
                k++;
            end
            feed(4, 0, 1, -1, -1, -1, 0);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(400);
        rand_ready = 0;
        m_ready    = 1'b1;
        repeat (3) tick();
        chk("rand_empty", m_valid,  0);
        chk("rand_no_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
